// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline's two memory ports, the arbiter and the
// single-port memory. The arbiter side uses the slave modport; the pipeline
// and memory model side uses the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // Memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Pipeline control
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the IF and
// MEM pipeline stages. Data wins by default; after STARVE_MAX data grants
// taken while a fetch waits, the fetch is forced through. Each access walks
// IDLE -> ISSUE -> WAIT -> DONE and completes with a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic              owner_d;     // 1 = data port owns the current access
  logic              we_r;        // write flag captured at grant
  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;

  logic any_req;
  logic starve_full;
  logic grant_d;
  logic last_wait;

  // Grant decision evaluated in IDLE: data wins unless the fetch is starved
  always_comb begin
    any_req     = bus.if_req | bus.d_req;
    starve_full = (starve_cnt == STV_W'(STARVE_MAX));
    grant_d     = bus.d_req & ~(bus.if_req & starve_full);
    last_wait   = (state == ST_WAIT) && (lat_cnt == LAT_W'(1));
  end

  // Access sequencing, ownership, latency countdown and starvation tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner_d    <= 1'b0;
      we_r       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_d <= grant_d;
            we_r    <= grant_d & bus.d_we;
            if (grant_d) begin
              if (bus.if_req && !starve_full)
                starve_cnt <= starve_cnt + STV_W'(1);
            end else begin
              starve_cnt <= '0;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt <= LAT_W'(MEM_LAT);
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (last_wait)
            state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory address/data captured at grant and read data captured on the last WAIT edge
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= '0;
      wdata_r    <= '0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        addr_r <= grant_d ? bus.d_addr : bus.if_addr;
        if (grant_d)
          wdata_r <= bus.d_wdata;
      end
      if (last_wait && !we_r) begin
        if (owner_d)
          d_rdata_r <= bus.mem_rdata;
        else
          if_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = (state == ST_ISSUE);
  assign bus.mem_we    = (state == ST_ISSUE) & we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.if_ack    = (state == ST_DONE) & ~owner_d;
  assign bus.d_ack     = (state == ST_DONE) & owner_d;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// accesses and expected acks; monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic is_d; logic [31:0] data; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;

  resp_t resp_q[$];
  acc_t  acc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int en_cyc = 0;
  bit mon_on = 1'b0;
  bit prev_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: returns data only in the cycle whose closing edge should sample it
  logic [31:0] mem_model [0:255];
  bit          mem_init = 1'b0;
  bit          pend = 1'b0;
  int          lcnt = 0;
  logic [31:0] ma = '0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
      mem_model[8'h10] <= 32'hDEADBEEF;
      mem_model[8'h20] <= 32'hCAFEF00D;
      mem_model[8'h30] <= 32'h13579BDF;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      pend <= 1'b1;
      lcnt <= 1;
      ma   <= bus.mem_addr;
      if (bus.mem_we) mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end else if (pend) begin
      if (lcnt == MEM_LAT) pend <= 1'b0;
      else lcnt <= lcnt + 1;
    end
  end

  assign bus.mem_rdata = (pend && lcnt == MEM_LAT) ? mem_model[ma[7:0]] : 32'hBAD0BAD0;

  // Monitor: memory accesses, acks, latency and stall relations
  always @(negedge clk) begin
    if (mon_on) begin
      acc_t  a;
      resp_t r;
      if (!bus.mem_en) chk("mem_we_unqualified", {31'b0, bus.mem_we}, 32'd0);
      chk("stall_if", {31'b0, bus.stall_if}, {31'b0, bus.if_req & ~bus.if_ack});
      chk("stall_mem", {31'b0, bus.stall_mem}, {31'b0, bus.d_req & ~bus.d_ack});
      if (bus.mem_en) begin
        chk("mem_en_single", {31'b0, prev_en}, 32'd0);
        en_cyc = cyc;
        if (acc_q.size() == 0) begin
          chk("unexpected_mem_en", 32'd1, 32'd0);
        end else begin
          a = acc_q.pop_front();
          chk("mem_we", {31'b0, bus.mem_we}, {31'b0, a.we});
          chk("mem_addr", bus.mem_addr, a.addr);
          if (a.we) chk("mem_wdata", bus.mem_wdata, a.wdata);
        end
      end
      if (bus.if_ack || bus.d_ack) begin
        chk("ack_both", {31'b0, bus.if_ack & bus.d_ack}, 32'd0);
        if (resp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("ack_port_is_d", {31'b0, bus.d_ack}, {31'b0, r.is_d});
          chk(r.is_d ? "d_rdata" : "if_rdata", r.is_d ? bus.d_rdata : bus.if_rdata, r.data);
          chk("ack_latency", cyc - en_cyc, MEM_LAT + 1);
        end
      end
      prev_en = bus.mem_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for an ack with a cycle bound, then returns just after the edge closing it
  task automatic wait_ack(input bit is_d, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = is_d ? bus.d_ack : bus.if_ack;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  task automatic push_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.we = we; a.addr = addr; a.wdata = wdata;
    acc_q.push_back(a);
  endtask

  task automatic push_resp(input logic is_d, input logic [31:0] data);
    resp_t r;
    r.is_d = is_d; r.data = data;
    resp_q.push_back(r);
  endtask

  initial begin
    int nd;
    int n;
    bit if_seen;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    step();
    rst = 1'b0;
    mon_on = 1'b1;
    step();

    // Single fetch of 0x10
    push_acc(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 32'hDEADBEEF);
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    @(negedge clk);
    chk("fetch_c0_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("fetch_c0_stall_if", {31'b0, bus.stall_if}, 32'd1);
    @(negedge clk);
    chk("fetch_c1_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("fetch_c1_busy", {31'b0, bus.busy}, 32'd1);
    wait_ack(1'b0, "fetch");
    bus.if_req = 1'b0;
    step();

    // Data read of 0x20, then write 0x1234 to 0x40, then read it back
    push_acc(1'b0, 32'h20, 32'h0);
    push_resp(1'b1, 32'hCAFEF00D);
    bus.d_addr = 32'h20; bus.d_we = 1'b0; bus.d_req = 1'b1;
    wait_ack(1'b1, "dread");
    bus.d_req = 1'b0;
    step();
    push_acc(1'b1, 32'h40, 32'h1234);
    push_resp(1'b1, 32'hCAFEF00D);
    bus.d_addr = 32'h40; bus.d_we = 1'b1; bus.d_wdata = 32'h1234; bus.d_req = 1'b1;
    wait_ack(1'b1, "dwrite");
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step();
    push_acc(1'b0, 32'h40, 32'h0);
    push_resp(1'b1, 32'h1234);
    bus.d_addr = 32'h40; bus.d_req = 1'b1;
    wait_ack(1'b1, "dreadback");
    bus.d_req = 1'b0;
    step();

    // Conflict: both request in the same IDLE cycle, data first
    push_acc(1'b0, 32'h20, 32'h0);
    push_acc(1'b0, 32'h10, 32'h0);
    push_resp(1'b1, 32'hCAFEF00D);
    push_resp(1'b0, 32'hDEADBEEF);
    bus.if_addr = 32'h10; bus.d_addr = 32'h20;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    wait_ack(1'b1, "conflict_d");
    bus.d_req = 1'b0;
    wait_ack(1'b0, "conflict_if");
    bus.if_req = 1'b0;
    step();

    // Starvation: continuous data requests with a pending fetch
    for (int i = 0; i < STARVE_MAX; i++) begin
      push_acc(1'b0, 32'h20, 32'h0);
      push_resp(1'b1, 32'hCAFEF00D);
    end
    push_acc(1'b0, 32'h30, 32'h0);
    push_resp(1'b0, 32'h13579BDF);
    push_acc(1'b0, 32'h20, 32'h0);
    push_resp(1'b1, 32'hCAFEF00D);
    bus.if_addr = 32'h30; bus.d_addr = 32'h20;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    nd = 0; n = 0;
    while (nd < STARVE_MAX + 1 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.d_ack) nd++;
      if_seen = bus.if_ack;
      step();
      if (if_seen) bus.if_req = 1'b0;
    end
    bus.d_req = 1'b0;
    chk("starve_data_acks", nd, STARVE_MAX + 1);
    step();

    // Address change and request drop during WAIT are ignored
    push_acc(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 32'hDEADBEEF);
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    step(); step();
    bus.if_addr = 32'h30; bus.if_req = 1'b0;
    @(negedge clk);
    chk("wait_mem_addr_hold", bus.mem_addr, 32'h10);
    wait_ack(1'b0, "dropped_req");
    step();

    // Reset during WAIT abandons the access
    push_acc(1'b0, 32'h20, 32'h0);
    bus.d_addr = 32'h20; bus.d_req = 1'b1;
    step(); step();
    rst = 1'b1; bus.d_req = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_d_ack", {31'b0, bus.d_ack}, 32'd0);
    chk("midrst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("midrst_mem_addr", bus.mem_addr, 32'd0);
    chk("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("midrst_if_rdata", bus.if_rdata, 32'd0);
    chk("midrst_d_rdata", bus.d_rdata, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Normal fetch after reset release
    push_acc(1'b0, 32'h10, 32'h0);
    push_resp(1'b0, 32'hDEADBEEF);
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    wait_ack(1'b0, "post_rst_fetch");
    bus.if_req = 1'b0;
    repeat (4) step();

    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("acc_q_drained", acc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
